// File: rtl/pcs_rx_block_sync.sv
// rtl/pcs_rx_block_sync.sv - 10GBASE-R RX block lock FSM with x^58+x^39+1 descrambler
module pcs_rx_block_sync #(
  parameter int LOCK_CNT  = 64,
  parameter int BAD_MAX   = 16,
  parameter int SLIP_WAIT = 2,
  parameter int ERR_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [63:0]      rx_data,
  input  logic [1:0]       rx_header,
  input  logic             rx_valid,
  output logic             rx_slip,
  output logic             block_lock,
  output logic [63:0]      dout_data,
  output logic [1:0]       dout_header,
  output logic             dout_valid,
  output logic [ERR_W-1:0] hdr_err_cnt,
  input  logic             err_cnt_clr
);

  localparam int SH_W   = $clog2(LOCK_CNT + 1);
  localparam int BAD_W  = $clog2(BAD_MAX + 1);
  localparam int WAIT_W = $clog2(SLIP_WAIT + 1);

  localparam logic [SH_W-1:0]   LOCK_CNT_V  = SH_W'(LOCK_CNT);
  localparam logic [BAD_W-1:0]  BAD_MAX_V   = BAD_W'(BAD_MAX);
  localparam logic [WAIT_W-1:0] SLIP_WAIT_V = WAIT_W'(SLIP_WAIT);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SLIP   = 2'd1,
    LOCKED = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [SH_W-1:0]    sh_cnt_q, sh_cnt_d;
  logic [BAD_W-1:0]   bad_cnt_q, bad_cnt_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic               rx_slip_q, rx_slip_d;
  logic               block_lock_q, block_lock_d;
  logic [ERR_W-1:0]   hdr_err_cnt_q, hdr_err_cnt_d;
  logic [57:0]        ds_state_q, ds_state_d;
  logic [63:0]        dout_data_q, dout_data_d;
  logic [1:0]         dout_header_q, dout_header_d;
  logic               dout_valid_q, dout_valid_d;

  logic               hdr_ok;
  logic [SH_W-1:0]    sh_inc;
  logic [BAD_W-1:0]   bad_inc;
  logic [WAIT_W-1:0]  wait_inc;
  logic [121:0]       ds_x;
  logic [63:0]        ds_out;

  // Only 01 and 10 are legal sync headers; the increments are shared by all FSM arms.
  always_comb begin
    hdr_ok   = (rx_header == 2'b01) || (rx_header == 2'b10);
    sh_inc   = sh_cnt_q + SH_W'(1);
    bad_inc  = bad_cnt_q + BAD_W'(1);
    wait_inc = wait_cnt_q + WAIT_W'(1);
  end

  // Block-lock FSM: hunt for LOCK_CNT good headers, slip on error, monitor while locked.
  always_comb begin
    state_d      = state_q;
    sh_cnt_d     = sh_cnt_q;
    bad_cnt_d    = bad_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    rx_slip_d    = 1'b0;
    block_lock_d = block_lock_q;
    if (rx_valid) begin
      unique case (state_q)
        HUNT: begin
          if (hdr_ok) begin
            if (sh_inc == LOCK_CNT_V) begin
              state_d      = LOCKED;
              block_lock_d = 1'b1;
              sh_cnt_d     = '0;
              bad_cnt_d    = '0;
            end else begin
              sh_cnt_d = sh_inc;
            end
          end else begin
            state_d    = SLIP;
            rx_slip_d  = 1'b1;
            sh_cnt_d   = '0;
            bad_cnt_d  = '0;
            wait_cnt_d = '0;
          end
        end
        SLIP: begin
          // Headers are ignored while the gearbox settles on its new alignment.
          if (wait_inc >= SLIP_WAIT_V) begin
            state_d    = HUNT;
            wait_cnt_d = '0;
          end else begin
            wait_cnt_d = wait_inc;
          end
        end
        LOCKED: begin
          // Losing lock takes priority over closing the window on the same block.
          if (!hdr_ok && (bad_inc == BAD_MAX_V)) begin
            state_d      = SLIP;
            block_lock_d = 1'b0;
            rx_slip_d    = 1'b1;
            sh_cnt_d     = '0;
            bad_cnt_d    = '0;
            wait_cnt_d   = '0;
          end else if (sh_inc == LOCK_CNT_V) begin
            sh_cnt_d  = '0;
            bad_cnt_d = '0;
          end else begin
            sh_cnt_d = sh_inc;
            if (!hdr_ok) begin
              bad_cnt_d = bad_inc;
            end
          end
        end
        default: begin
          state_d      = HUNT;
          block_lock_d = 1'b0;
          sh_cnt_d     = '0;
          bad_cnt_d    = '0;
          wait_cnt_d   = '0;
        end
      endcase
    end
  end

  // Saturating invalid-header counter; a clear request overrides a coincident increment.
  always_comb begin
    hdr_err_cnt_d = hdr_err_cnt_q;
    if (err_cnt_clr) begin
      hdr_err_cnt_d = '0;
    end else if (rx_valid && (state_q == LOCKED) && !hdr_ok &&
                 (hdr_err_cnt_q != {ERR_W{1'b1}})) begin
      hdr_err_cnt_d = hdr_err_cnt_q + ERR_W'(1);
    end
  end

  // Parallel feed-forward descrambler: ds_x[58+k] is payload bit k, ds_x[j<58] the history.
  always_comb begin
    ds_x   = {rx_data, ds_state_q};
    ds_out = '0;
    for (int k = 0; k < 64; k++) begin
      ds_out[k] = ds_x[k + 58] ^ ds_x[k + 19] ^ ds_x[k];
    end
    ds_state_d = rx_valid ? rx_data[63:6] : ds_state_q;
  end

  // Output stage: capture descrambled block only when valid and already locked.
  always_comb begin
    dout_valid_d  = rx_valid & block_lock_q;
    dout_data_d   = dout_data_q;
    dout_header_d = dout_header_q;
    if (rx_valid && block_lock_q) begin
      dout_data_d   = ds_out;
      dout_header_d = rx_header;
    end
  end

  // State register for FSM, counters, descrambler history and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= HUNT;
      sh_cnt_q      <= '0;
      bad_cnt_q     <= '0;
      wait_cnt_q    <= '0;
      rx_slip_q     <= 1'b0;
      block_lock_q  <= 1'b0;
      hdr_err_cnt_q <= '0;
      ds_state_q    <= {58{1'b1}};
      dout_data_q   <= '0;
      dout_header_q <= '0;
      dout_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      sh_cnt_q      <= sh_cnt_d;
      bad_cnt_q     <= bad_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      rx_slip_q     <= rx_slip_d;
      block_lock_q  <= block_lock_d;
      hdr_err_cnt_q <= hdr_err_cnt_d;
      ds_state_q    <= ds_state_d;
      dout_data_q   <= dout_data_d;
      dout_header_q <= dout_header_d;
      dout_valid_q  <= dout_valid_d;
    end
  end

  assign rx_slip     = rx_slip_q;
  assign block_lock  = block_lock_q;
  assign dout_data   = dout_data_q;
  assign dout_header = dout_header_q;
  assign dout_valid  = dout_valid_q;
  assign hdr_err_cnt = hdr_err_cnt_q;

endmodule

// File: tb/tb_pcs_rx_block_sync.sv
// tb/tb_pcs_rx_block_sync.sv - directed self-checking bench for pcs_rx_block_sync
module tb_pcs_rx_block_sync;

  logic        clk         = 1'b0;
  logic        rst_n       = 1'b0;
  logic [63:0] rx_data     = '0;
  logic [1:0]  rx_header   = 2'b01;
  logic        rx_valid    = 1'b0;
  logic        err_cnt_clr = 1'b0;
  logic        rx_slip;
  logic        block_lock;
  logic [63:0] dout_data;
  logic [1:0]  dout_header;
  logic        dout_valid;
  logic [7:0]  hdr_err_cnt;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          nslip;
  logic [57:0] tx_st;
  logic [63:0] seed;
  logic [63:0] d;
  logic [63:0] s;
  logic [1:0]  h;

  pcs_rx_block_sync #(
    .LOCK_CNT (64),
    .BAD_MAX  (16),
    .SLIP_WAIT(2),
    .ERR_W    (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_header  (rx_header),
    .rx_valid   (rx_valid),
    .rx_slip    (rx_slip),
    .block_lock (block_lock),
    .dout_data  (dout_data),
    .dout_header(dout_header),
    .dout_valid (dout_valid),
    .hdr_err_cnt(hdr_err_cnt),
    .err_cnt_clr(err_cnt_clr)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic blk(input logic v, input logic [1:0] hh, input logic [63:0] dd);
    rx_valid  = v;
    rx_header = hh;
    rx_data   = dd;
    cyc();
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rx_valid    = 1'b0;
    err_cnt_clr = 1'b0;
    rst_n       = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  // Serial TX scrambler: s[k] = d[k] ^ s[k-39] ^ s[k-58]; tx_st[57] is the newest bit.
  task automatic scramble(input logic [63:0] din, output logic [63:0] sout);
    logic b;
    sout = '0;
    for (int k = 0; k < 64; k++) begin
      b       = din[k] ^ tx_st[19] ^ tx_st[0];
      sout[k] = b;
      tx_st   = {b, tx_st[57:1]};
    end
  endtask

  task automatic lock_up();
    for (int i = 0; i < 64; i++) blk(1'b1, 2'b01, '0);
    chkb("lock_up", block_lock, 1'b1);
  endtask

  initial begin
    // Reset state
    cyc();
    cyc();
    chkb("rst_lock", block_lock, 1'b0);
    chkb("rst_slip", rx_slip, 1'b0);
    chkb("rst_dv", dout_valid, 1'b0);
    chkw("rst_data", dout_data, 64'd0);
    chkw("rst_hdr", 64'(dout_header), 64'd0);
    chkw("rst_err", 64'(hdr_err_cnt), 64'd0);
    rst_n = 1'b1;

    // 1: 70 good blocks of zero data; lock after block 64, dout_valid from block 65
    for (int i = 0; i < 70; i++) begin
      blk(1'b1, 2'b01, '0);
      chkb("t1_lock", block_lock, i >= 63);
      chkb("t1_dv", dout_valid, i >= 64);
      chkb("t1_slip", rx_slip, 1'b0);
      chkw("t1_data", dout_data, 64'd0);
    end
    chkw("t1_hdr", 64'(dout_header), 64'd1);

    // 2: scrambler loopback from reset; after lock output equals TX input of that block
    do_reset();
    seed  = 64'h9bd3c750ce28aac0;
    tx_st = seed[57:0];
    for (int i = 0; i < 84; i++) begin
      d = {$urandom, $urandom};
      h = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
      scramble(d, s);
      blk(1'b1, h, s);
      if (i >= 64) begin
        chkw("t2_data", dout_data, d);
        chkw("t2_hdr", 64'(dout_header), 64'(h));
        chkb("t2_dv", dout_valid, 1'b1);
      end
    end

    // 3: misaligned start; every header 11 gives slips only on hunted blocks
    do_reset();
    nslip = 0;
    for (int i = 0; i < 9; i++) begin
      blk(1'b1, 2'b11, '0);
      chkb("t3_slip", rx_slip, (i % 3) == 0);
      chkb("t3_nolock", block_lock, 1'b0);
      nslip += int'(rx_slip);
    end
    chkw("t3_nslip", 64'(nslip), 64'd3);
    for (int i = 0; i < 64; i++) begin
      blk(1'b1, 2'b10, '0);
      chkb("t3_lock", block_lock, i == 63);
      chkb("t3_noslip", rx_slip, 1'b0);
    end

    // 4: 15 bad in a window keeps lock, 16th drops it with a slip pulse
    do_reset();
    lock_up();
    for (int i = 0; i < 15; i++) begin
      blk(1'b1, 2'b00, '0);
      chkb("t4_lock", block_lock, 1'b1);
      chkb("t4_noslip", rx_slip, 1'b0);
    end
    chkw("t4_err15", 64'(hdr_err_cnt), 64'd15);
    blk(1'b1, 2'b11, '0);
    chkb("t4_unlock", block_lock, 1'b0);
    chkb("t4_slip", rx_slip, 1'b1);
    chkw("t4_err16", 64'(hdr_err_cnt), 64'd16);
    blk(1'b0, 2'b01, '0);
    chkb("t4_slip_pulse", rx_slip, 1'b0);
    chkb("t4_dv_off", dout_valid, 1'b0);

    // 5: 15 bad per window never unlocks; idle gaps do not advance the window
    do_reset();
    lock_up();
    for (int i = 0; i < 64; i++) begin
      blk(1'b1, (i < 15) ? 2'b00 : 2'b01, '0);
      chkb("t5_w1_lock", block_lock, 1'b1);
    end
    chkw("t5_err_w1", 64'(hdr_err_cnt), 64'd15);
    for (int i = 0; i < 15; i++) blk(1'b1, 2'b11, '0);
    for (int i = 0; i < 10; i++) begin
      blk(1'b0, 2'b11, '0);
      chkb("t5_gap_dv", dout_valid, 1'b0);
    end
    chkw("t5_gap_err", 64'(hdr_err_cnt), 64'd30);
    for (int i = 0; i < 48; i++) blk(1'b1, 2'b01, '0);
    chkb("t5_w2_lock", block_lock, 1'b1);
    chkb("t5_w2_noslip", rx_slip, 1'b0);
    // 64th valid block of window 2 is also its 16th bad header: unlock wins
    blk(1'b1, 2'b00, '0);
    chkb("t5_unlock", block_lock, 1'b0);
    chkb("t5_slip", rx_slip, 1'b1);
    chkw("t5_err31", 64'(hdr_err_cnt), 64'd31);

    // 6: async reset mid-stream while locked, full relock, clear beats increment
    do_reset();
    lock_up();
    blk(1'b1, 2'b00, '0);
    blk(1'b1, 2'b10, 64'h1);
    chkw("t6_pre_err", 64'(hdr_err_cnt), 64'd1);
    chkw("t6_pre_hdr", 64'(dout_header), 64'd2);
    #3;
    rst_n = 1'b0;
    #1;
    chkb("t6_rst_lock", block_lock, 1'b0);
    chkb("t6_rst_dv", dout_valid, 1'b0);
    chkb("t6_rst_slip", rx_slip, 1'b0);
    chkw("t6_rst_data", dout_data, 64'd0);
    chkw("t6_rst_hdr", 64'(dout_header), 64'd0);
    chkw("t6_rst_err", 64'(hdr_err_cnt), 64'd0);
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) begin
      blk(1'b1, 2'b01, '0);
      chkb("t6_relock", block_lock, i == 63);
    end
    blk(1'b1, 2'b11, '0);
    chkw("t6_err1", 64'(hdr_err_cnt), 64'd1);
    err_cnt_clr = 1'b1;
    blk(1'b1, 2'b00, '0);
    err_cnt_clr = 1'b0;
    chkw("t6_clr", 64'(hdr_err_cnt), 64'd0);
    chkb("t6_still_lock", block_lock, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
